stopwatch_counter: RTL
======================

# stopwatch_counter

Timekeeping datapath that consumes the run/pause `enable` produced by the stopwatch control FSM. It keeps an MM:SS elapsed time in BCD, from 00:00 to 99:59. A parameterised prescaler divides the system clock down to one-second ticks, and the block supplies registered digits to the display driver. A pause retains the partial second; a clear returns everything to zero.

## Interface
- `TICKS_PER_SEC`, default 100000000: enabled clock cycles per elapsed second; must be ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  count enable, driven by the control FSM (high only in RUNNING).
- `clear`  in  1  synchronous clear; top level drives it high while the FSM status is IDLE.
- `min_tens`  out  4  minutes tens digit, BCD 0–9.
- `min_ones`  out  4  minutes ones digit, BCD 0–9.
- `sec_tens`  out  4  seconds tens digit, BCD 0–5.
- `sec_ones`  out  4  seconds ones digit, BCD 0–9.
- `sec_tick`  out  1  one-cycle pulse marking each digit increment.
- `rollover`  out  1  one-cycle pulse on the 99:59 → 00:00 wrap.

## Operation
- **Prescaler.** Width is `$clog2(TICKS_PER_SEC)`. On a clock edge with `enable`=1 and `clear`=0:
  - If the prescaler equals `TICKS_PER_SEC-1`, it wraps to 0 and the time increments.
  - Otherwise the prescaler increments by 1.
- **Pause.** With `enable`=0 the prescaler and digits hold. The partial second is preserved, and resume continues from the held count.
- **Digit chain.** The chain is sec_ones (0–9) → sec_tens (0–5) → min_ones (0–9) → min_tens (0–9).
  - Each digit wraps to 0 and carries into the next when incremented at its maximum.
  - A carry ripples within the same increment edge, e.g. 09:59 → 10:00 in one cycle.
- **Wrap.** 99:59 + 1 s gives 00:00. `rollover` and `sec_tick` both pulse, and counting continues.
- **Clear.**
  - `clear`=1 zeroes the prescaler and all digits on the next edge.
  - It has priority over `enable`; no `sec_tick` or `rollover` is generated in that cycle.
- **Digit legality.** Digits never hold non-BCD values. Illegal values can be reached only by fault; the next increment then forces that digit to 0.
- **Reset.** `rst` asserted at any time (including mid-count or mid-carry) immediately sets all digits to 0, the prescaler to 0, and `sec_tick`/`rollover` to 0.

## Timing
- Reset values of every output: all digits 0, `sec_tick` 0, `rollover` 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Latency.** The first increment occurs on the `TICKS_PER_SEC`-th rising edge at which `enable`=1 and `clear`=0 is sampled, counted from a cleared state.
  - Updated digits and `sec_tick` become visible in the same cycle after that edge.
  - `sec_tick` stays high exactly one cycle.
- **Enable gaps.** Enable-low cycles do not count and do not reset progress. Total enabled cycles decide the tick time.
- **Clear timing.** `clear` takes effect one edge after sampling. `enable` is ignored while `clear`=1.
- **Simultaneous clear and prescaler terminal count:** clear wins, digits go to 00:00, no pulse.
- **Reset release.** Counting starts on the first edge after `rst` deasserts, if `enable`=1.

## Structure
- Package `stopwatch_pkg` holds:
  - `BCD_W` = 4.
  - `SEC_TENS_MAX` = 5, `DIGIT_MAX` = 9.
  - The default `TICKS_PER_SEC` constant, shared with the control FSM top level.
- Sub-module `bcd_digit_counter`:
  - Parameter: `MAX`.
  - Inputs: `clk`, `rst`, `clear`, `inc`.
  - Outputs: `digit[3:0]`, registered; `carry`, combinational, equal to `inc` && `digit==MAX`.
  - It is instantiated four times, chained through `carry` → `inc`.
- The prescaler, `sec_tick` register and `rollover` register live in `stopwatch_counter`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4.
- **Reset:** assert `rst` mid-count, then release → all digits 0 and both pulses 0 immediately; 4 enabled cycles later → 00:01.
- **Basic count:** `enable` held high 40 cycles from 00:00 → 00:10. `sec_tick` pulses 10 times, each exactly 1 cycle wide, 4 cycles apart.
- **Pause:** enable 2 cycles, disable 10 cycles, enable 2 cycles → 00:01 with a single `sec_tick`. A further 3 enabled cycles show no change.
- **Carry ripple:** preload by counting to 09:59, then 4 enabled cycles → 10:00 in one step. Also 00:59 → 01:00.
- **Wrap:** run to 99:59, then 4 enabled cycles → 00:00. `rollover` and `sec_tick` are high together for 1 cycle.
- **Clear priority:** at 03:27 with the prescaler at 3, assert `clear` and `enable` together → 00:00 next cycle, no `sec_tick`. The next increment needs a full 4 enabled cycles.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: BCD digit width, per-digit maxima and
// the default prescaler ratio used by the control FSM top level.
package stopwatch_pkg;
    localparam int BCD_W                 = 4;
    localparam int SEC_TENS_MAX          = 5;
    localparam int DIGIT_MAX             = 9;
    localparam int TICKS_PER_SEC_DEFAULT = 100_000_000;
endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the elapsed-time chain: counts 0..MAX on inc, wraps to 0
// and raises a combinational carry so the next digit advances on the same edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = DIGIT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);
    localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

    logic [BCD_W-1:0] digit_q, digit_d;

    // ">=" rather than "==" so a corrupted non-BCD value is forced back to 0
    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q >= MAX_V) ? '0 : digit_q + BCD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == MAX_V);
endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD elapsed-time counter: a prescaler turns enabled clock cycles into
// one-second increments that ripple through four chained digit counters.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             sec_tick,
    output logic             rollover
);
    localparam int          PW   = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          sec_tick_q, sec_tick_d;
    logic          rollover_q, rollover_d;
    logic          tick;
    logic          c_so, c_st, c_mo, c_mt;

    // Clear dominates, so a terminal count coinciding with clear produces no tick
    assign tick = enable && !clear && (presc_q == TERM);

    always_comb begin
        presc_d    = presc_q;
        sec_tick_d = tick;
        rollover_d = c_mt;
        if (clear) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            rollover_q <= rollover_d;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clear(clear), .inc(tick), .digit(sec_ones), .carry(c_so)
    );
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clear(clear), .inc(c_so), .digit(sec_tens), .carry(c_st)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clear(clear), .inc(c_st), .digit(min_ones), .carry(c_mo)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clear(clear), .inc(c_mo), .digit(min_tens), .carry(c_mt)
    );

    assign sec_tick = sec_tick_q;
    assign rollover = rollover_q;
endmodule
